// File: rtl/rbus_mux5x1_arb_if.sv
// rbus concentrator bus bundle: N source channels in, one merged channel out.
//   i_stb/i_sof/i_data : per-input word strobe, start of packet, 72-bit word
//   i_rdy              : per-input, per-class "may start a packet" (registered)
//   i_rdyE             : per-input, per-class "buffer empty and downstream class empty"
//   o_stb/o_sof/o_data : merged output word stream
//   o_rdy/o_rdyE       : downstream per-class ready / empty
//   ff_err             : sticky protocol/overflow error
// master = traffic side (sources + consumer), slave = the concentrator.
interface rbus_mux5x1_arb_if #(
    parameter int unsigned N = 5
) ();
    localparam int unsigned DW = 72;

    logic [N-1:0]          i_stb;
    logic [N-1:0]          i_sof;
    logic [N-1:0][DW-1:0]  i_data;
    logic [N-1:0][1:0]     i_rdy;
    logic [N-1:0][1:0]     i_rdyE;
    logic                  o_stb;
    logic                  o_sof;
    logic [DW-1:0]         o_data;
    logic [1:0]            o_rdy;
    logic [1:0]            o_rdyE;
    logic                  ff_err;

    modport master (
        output i_stb, i_sof, i_data, o_rdy, o_rdyE,
        input  i_rdy, i_rdyE, o_stb, o_sof, o_data, ff_err
    );

    modport slave (
        input  i_stb, i_sof, i_data, o_rdy, o_rdyE,
        output i_rdy, i_rdyE, o_stb, o_sof, o_data, ff_err
    );
endinterface

// File: rtl/rbus_mux5x1_arb.sv
// rbus N-to-1 packet concentrator. Each input owns a one-packet store-and-forward
// buffer; a round-robin arbiter grants whole packets whose class is ready
// downstream and streams them out without interleaving.
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : rbus_mux5x1_arb_if.slave (per-input word streams, merged output,
//          per-class ready/empty handshakes, sticky ff_err)
module rbus_mux5x1_arb #(
    parameter int unsigned N     = 5,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    rbus_mux5x1_arb_if.slave        bus
);
    localparam int unsigned DW = 72;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL} buf_st_e;
    typedef enum logic {S_IDLE, S_SEND} out_st_e;

    // Per-input buffer state
    buf_st_e        buf_st_q [N];
    buf_st_e        buf_st_d [N];
    logic [CW-1:0]  wcnt_q   [N];
    logic [CW-1:0]  wcnt_d   [N];
    logic [3:0]     len_q    [N];
    logic [3:0]     len_d    [N];
    logic [N-1:0]   cls_q;
    logic [N-1:0]   cls_d;
    logic [N-1:0]   empty_q;
    logic [N-1:0]   wr_en;
    logic [AW-1:0]  wr_addr  [N];
    logic [DW-1:0]  mem_q    [N][DEPTH];
    logic           err_q;
    logic           err_set;

    // Output side
    out_st_e        st_q;
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  gnt_q;
    logic [CW-1:0]  rd_cnt_q;
    logic           o_stb_q;
    logic           o_sof_q;
    logic [DW-1:0]  o_data_q;
    logic [N-1:0]   cand;
    logic [N-1:0]   rel;
    logic           send_done;
    logic           gnt_vld_d;
    logic [IW-1:0]  gnt_idx_d;
    logic [IW-1:0]  sel;

    // Current packet has had every word loaded into the output register.
    assign send_done = (st_q == S_SEND) &&
                       (rd_cnt_q == CW'(len_q[gnt_q]) + CW'(1));

    // Buffer next-state, write enables and protocol error detection.
    always_comb begin
        err_set = 1'b0;
        for (int n = 0; n < N; n++) begin
            buf_st_d[n] = buf_st_q[n];
            wcnt_d[n]   = wcnt_q[n];
            len_d[n]    = len_q[n];
            cls_d[n]    = cls_q[n];
            wr_en[n]    = 1'b0;
            wr_addr[n]  = wcnt_q[n][AW-1:0];
            rel[n]      = send_done && (gnt_q == IW'(n));
            case (buf_st_q[n])
                B_EMPTY, B_FILL: begin
                    if (bus.i_stb[n] && bus.i_sof[n]) begin
                        // A header mid-fill restarts the buffer with the new packet.
                        if (buf_st_q[n] == B_FILL) err_set = 1'b1;
                        wr_en[n]    = 1'b1;
                        wr_addr[n]  = '0;
                        cls_d[n]    = bus.i_data[n][71];
                        len_d[n]    = bus.i_data[n][69:66];
                        wcnt_d[n]   = CW'(1);
                        buf_st_d[n] = (bus.i_data[n][69:66] == 4'd0) ? B_FULL : B_FILL;
                    end else if (bus.i_stb[n]) begin
                        if (buf_st_q[n] == B_EMPTY) begin
                            err_set = 1'b1;
                        end else begin
                            wr_en[n]  = 1'b1;
                            wcnt_d[n] = wcnt_q[n] + CW'(1);
                            if (wcnt_q[n] == CW'(len_q[n])) buf_st_d[n] = B_FULL;
                        end
                    end
                end
                B_FULL: begin
                    if (bus.i_stb[n]) err_set = 1'b1;
                    if (rel[n]) buf_st_d[n] = B_EMPTY;
                end
                default: buf_st_d[n] = B_EMPTY;
            endcase
        end
    end

    // Buffer control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N; n++) begin
                buf_st_q[n] <= B_EMPTY;
                wcnt_q[n]   <= '0;
                len_q[n]    <= '0;
            end
            cls_q   <= '0;
            empty_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int n = 0; n < N; n++) begin
                buf_st_q[n] <= buf_st_d[n];
                wcnt_q[n]   <= wcnt_d[n];
                len_q[n]    <= len_d[n];
                empty_q[n]  <= (buf_st_d[n] == B_EMPTY);
            end
            cls_q <= cls_d;
            err_q <= err_q | err_set;
        end
    end

    // Packet storage (data only, no reset needed).
    always_ff @(posedge clk) begin
        for (int n = 0; n < N; n++) begin
            if (wr_en[n]) mem_q[n][wr_addr[n]] <= bus.i_data[n];
        end
    end

    // Round-robin pick: first FULL input with its class ready, scanning up from ptr.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_idx_d = '0;
        sel       = '0;
        for (int n = 0; n < N; n++) begin
            cand[n] = (buf_st_q[n] == B_FULL) && bus.o_rdy[cls_q[n]];
        end
        for (int unsigned i = 0; i < N; i++) begin
            sel = IW'((32'(ptr_q) + i) % N);
            if (!gnt_vld_d && cand[sel]) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = sel;
            end
        end
    end

    // Output FSM: grant in IDLE loads word 0, SEND streams the rest back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= S_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            rd_cnt_q <= '0;
            o_stb_q  <= 1'b0;
            o_sof_q  <= 1'b0;
            o_data_q <= '0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    o_stb_q <= 1'b0;
                    o_sof_q <= 1'b0;
                    if (gnt_vld_d) begin
                        st_q     <= S_SEND;
                        gnt_q    <= gnt_idx_d;
                        ptr_q    <= (gnt_idx_d == IW'(N - 1)) ? '0 : gnt_idx_d + IW'(1);
                        o_stb_q  <= 1'b1;
                        o_sof_q  <= 1'b1;
                        o_data_q <= mem_q[gnt_idx_d][0];
                        rd_cnt_q <= CW'(1);
                    end
                end
                S_SEND: begin
                    o_sof_q <= 1'b0;
                    if (send_done) begin
                        o_stb_q <= 1'b0;
                        st_q    <= S_IDLE;
                    end else begin
                        o_stb_q  <= 1'b1;
                        o_data_q <= mem_q[gnt_q][rd_cnt_q[AW-1:0]];
                        rd_cnt_q <= rd_cnt_q + CW'(1);
                    end
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    // Ready flags: i_rdy is the registered EMPTY flag, i_rdyE also folds in o_rdyE.
    always_comb begin
        for (int n = 0; n < N; n++) begin
            bus.i_rdy[n]  = {2{empty_q[n]}};
            bus.i_rdyE[n] = {2{buf_st_q[n] == B_EMPTY}} & bus.o_rdyE;
        end
    end

    assign bus.o_stb  = o_stb_q;
    assign bus.o_sof  = o_sof_q;
    assign bus.o_data = o_data_q;
    assign bus.ff_err = err_q;

endmodule

// File: tb/tb_rbus_mux5x1_arb.sv
// Testbench for rbus_mux5x1_arb: directed scenarios plus randomized packet
// batches, checked against a packet-level round-robin reference model.
module tb_rbus_mux5x1_arb;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    rbus_mux5x1_arb_if #(.N(N)) bus ();

    rbus_mux5x1_arb #(.N(N), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    logic [71:0] mon_w[$];
    logic        mon_sof[$];
    int          mon_cyc[$];
    always @(negedge clk) begin
        if (!rst && bus.o_stb) begin
            mon_w.push_back(bus.o_data);
            mon_sof.push_back(bus.o_sof);
            mon_cyc.push_back(cyc);
        end
    end

    // Reference model: stored packet per input, class, round-robin pointer
    logic [71:0] m_pkt [N][$];
    logic        m_full [N];
    logic        m_cls  [N];
    int          m_ptr;
    logic [71:0] exp_w[$];
    logic        exp_sof[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mk_word();
        return {8'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            m_pkt[n].delete();
            m_full[n] = 1'b0;
            m_cls[n]  = 1'b0;
        end
        m_ptr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_stb = '0;
        bus.i_sof = '0;
        bus.o_rdy = '0;
        tick();
        tick();
        chk("rst_o_stb", 72'(bus.o_stb), 72'(0));
        chk("rst_o_sof", 72'(bus.o_sof), 72'(0));
        chk("rst_o_data", bus.o_data, 72'(0));
        chk("rst_ff_err", 72'(bus.ff_err), 72'(0));
        chk("rst_i_rdy_held", 72'(bus.i_rdy), 72'(0));
        rst = 1'b0;
        tick();
        chk("rst_i_rdy_release", 72'(bus.i_rdy), 72'({N{2'b11}}));
        model_reset();
    endtask

    // Push a complete packet into input ch, one word per cycle.
    task automatic load(input int ch, input logic cls, input int len);
        logic [71:0] w;
        m_pkt[ch].delete();
        for (int i = 0; i <= len; i++) begin
            w = mk_word();
            if (i == 0) begin
                w[71]    = cls;
                w[69:66] = 4'(len);
            end
            bus.i_stb[ch]  = 1'b1;
            bus.i_sof[ch]  = (i == 0);
            bus.i_data[ch] = w;
            m_pkt[ch].push_back(w);
            tick();
        end
        bus.i_stb[ch] = 1'b0;
        bus.i_sof[ch] = 1'b0;
        m_full[ch] = 1'b1;
        m_cls[ch]  = cls;
    endtask

    // Expected output: repeatedly take the first loaded, class-ready input from ptr.
    task automatic model_serve(input logic [1:0] rdy);
        int pick;
        for (int step = 0; step < N; step++) begin
            pick = -1;
            for (int i = 0; i < N; i++) begin
                if (pick < 0 && m_full[(m_ptr + i) % N] && rdy[m_cls[(m_ptr + i) % N]])
                    pick = (m_ptr + i) % N;
            end
            if (pick < 0) break;
            for (int j = 0; j < m_pkt[pick].size(); j++) begin
                exp_w.push_back(m_pkt[pick][j]);
                exp_sof.push_back(j == 0);
            end
            m_full[pick] = 1'b0;
            m_pkt[pick].delete();
            m_ptr = (pick + 1) % N;
        end
    endtask

    // Open o_rdy, let everything eligible drain, compare the captured stream.
    task automatic drain(input string tag, input logic [1:0] rdy);
        int budget;
        exp_w.delete();
        exp_sof.delete();
        mon_w.delete();
        mon_sof.delete();
        mon_cyc.delete();
        model_serve(rdy);
        bus.o_rdy = rdy;
        budget = 2 * exp_w.size() + 8;
        repeat (budget) tick();
        bus.o_rdy = '0;
        chk({tag, "_count"}, 72'(mon_w.size()), 72'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < mon_w.size(); i++) begin
            chk({tag, "_data"}, mon_w[i], exp_w[i]);
            chk({tag, "_sof"}, 72'(mon_sof[i]), 72'(exp_sof[i]));
            if (i > 0)
                chk({tag, "_spacing"}, 72'(mon_cyc[i]), 72'(mon_cyc[i-1] + (exp_sof[i] ? 2 : 1)));
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.i_stb  = '0;
        bus.i_sof  = '0;
        bus.i_data = '0;
        bus.o_rdy  = '0;
        bus.o_rdyE = '0;
        model_reset();
        do_reset();

        // Single 4-word class-0 packet on input 2 with detailed timing.
        bus.o_rdy = 2'b01;
        load(2, 1'b0, 3);
        chk("single_no_early_stb", 72'(bus.o_stb), 72'(0));
        chk("single_rdy_low", 72'(bus.i_rdy[2]), 72'(0));
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("single_stb", 72'(bus.o_stb), 72'(1));
            chk("single_sof", 72'(bus.o_sof), 72'(j == 0));
            chk("single_data", bus.o_data, m_pkt[2][j]);
            chk("single_rdy_busy", 72'(bus.i_rdy[2]), 72'(0));
        end
        tick();
        chk("single_stb_end", 72'(bus.o_stb), 72'(0));
        chk("single_rdy_back", 72'(bus.i_rdy[2]), 72'(2'b11));
        bus.o_rdy = '0;
        m_pkt[2].delete();
        m_full[2] = 1'b0;
        m_ptr = 3;

        // Fairness from ptr=0, then refill 3 and 0: 0 must be next after 4.
        do_reset();
        for (int n = 0; n < N; n++) load(n, 1'($urandom), 0);
        drain("fair", 2'b11);
        load(3, 1'b0, 0);
        load(0, 1'b1, 0);
        drain("fair_refill", 2'b11);

        // Class gating.
        load(0, 1'b1, int'($urandom_range(3, 0)));
        load(1, 1'b0, int'($urandom_range(3, 0)));
        drain("gate_c0", 2'b01);
        drain("gate_c1", 2'b10);

        // Errors: stray word on EMPTY, 17th word on FULL, header while filling.
        do_reset();
        bus.i_stb[4]  = 1'b1;
        bus.i_sof[4]  = 1'b0;
        bus.i_data[4] = mk_word();
        tick();
        bus.i_stb[4] = 1'b0;
        chk("err_stray", 72'(bus.ff_err), 72'(1));
        chk("err_stray_rdy", 72'(bus.i_rdy[4]), 72'(2'b11));
        drain("err_no_out", 2'b11);
        load(1, 1'b0, 15);
        bus.i_stb[1]  = 1'b1;
        bus.i_data[1] = mk_word();
        tick();
        bus.i_stb[1] = 1'b0;
        drain("max_len", 2'b01);
        for (int i = 0; i < 2; i++) begin
            bus.i_stb[2]  = 1'b1;
            bus.i_sof[2]  = (i == 0);
            bus.i_data[2] = {1'b0, 1'b0, 4'd3, 66'(mk_word())};
            tick();
        end
        bus.i_stb[2] = 1'b0;
        bus.i_sof[2] = 1'b0;
        load(2, 1'b0, 1);
        drain("restart", 2'b11);
        chk("err_sticky", 72'(bus.ff_err), 72'(1));

        // Reset mid-SEND discards the active and the stored packet.
        do_reset();
        load(0, 1'b1, 15);
        load(2, 1'b0, 3);
        bus.o_rdy = 2'b11;
        tick();
        tick();
        tick();
        chk("pre_rst_stb", 72'(bus.o_stb), 72'(1));
        rst = 1'b1;
        #1;
        chk("rst_async_stb", 72'(bus.o_stb), 72'(0));
        do_reset();
        mon_w.delete();
        mon_sof.delete();
        mon_cyc.delete();
        bus.o_rdy = 2'b11;
        repeat (10) tick();
        bus.o_rdy = '0;
        chk("post_rst_quiet", 72'(mon_w.size()), 72'(0));
        chk("post_rst_rdy", 72'(bus.i_rdy), 72'({N{2'b11}}));

        // i_rdyE follows EMPTY and o_rdyE.
        bus.o_rdyE = 2'b10;
        #1;
        chk("rdyE_empty", 72'(bus.i_rdyE[3]), 72'(2'b10));
        load(3, 1'b0, 0);
        chk("rdyE_full", 72'(bus.i_rdyE[3]), 72'(0));
        chk("rdyE_other", 72'(bus.i_rdyE[2]), 72'(2'b10));
        drain("rdyE_drain", 2'b11);
        chk("rdyE_back", 72'(bus.i_rdyE[3]), 72'(2'b10));
        bus.o_rdyE = '0;

        // Randomized batches with random downstream readiness.
        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(1, 0) == 1)
                    load(n, 1'($urandom), int'($urandom_range(15, 0)));
            end
            drain("rand_part", 2'($urandom));
            drain("rand_flush", 2'b11);
        end
        chk("final_err_clear", 72'(bus.ff_err), 72'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rbus_mux5x1_arb.md
Name: rbus_mux5x1_arb

Overview:
- Packet-level concentrator for the rbus: merges N independent rbus source channels onto one rbus output.
- It is the converging counterpart of the 1-to-5 fan-out crossbar; it sits in front of a shared consumer (memory port, host link).
- Each input has a one-packet store-and-forward buffer.
- A round-robin arbiter grants complete packets whose class is ready downstream.
- Packets are never interleaved on the output.

Parameters:
- N, 5, number of input channels (2..8).
- DEPTH, 16, words per input buffer; must be at least the maximum packet length (16).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_stb  in  1 x[0:N-1]  word strobe per input
- i_sof  in  1 x[0:N-1]  start of packet; valid only with i_stb
- i_data  in  72 x[0:N-1]  word. Header fields: [71] class k, [69:66] LEN, where packet length = LEN+1 words.
- i_rdy  out  2 x[0:N-1]  per class: input may start a packet of class k
- i_rdyE  out  2 x[0:N-1]  per class: input buffer empty AND o_rdyE[k]
- o_stb  out  1  output word strobe
- o_sof  out  1  output start of packet
- o_data  out  72  output word
- o_rdy  in  2  downstream can accept one packet of class k
- o_rdyE  in  2  downstream class k path empty
- ff_err  out  1  sticky protocol/overflow error

Behaviour:
- Reset:
  - all outputs 0; ff_err 0; buffers empty; arbiter pointer = 0; FSM in IDLE.
  - Reset mid-packet discards all partial and stored packets; no output word is emitted after reset.
- Input buffer n (per channel):
  - States EMPTY, FILL, FULL.
  - EMPTY + i_stb & i_sof: latch class and LEN, write word 0, go to FILL. If LEN == 0, go directly to FULL.
  - FILL: each i_stb writes the next word. When the word count reaches LEN+1, go to FULL.
  - FULL: hold the packet until the output finishes reading it, then go to EMPTY on the cycle after the last word leaves.
  - i_rdy[n][k] = buffer EMPTY, registered, both classes identical. i_rdyE[n][k] = EMPTY & o_rdyE[k], combinational.
- Errors (set ff_err, sticky until rst):
  - i_stb while FULL: word dropped.
  - i_stb & ~i_sof while EMPTY: word dropped.
  - i_sof while FILL: the word is treated as a new header and the partial packet is discarded.
  - All errors are registered; ff_err rises 1 cycle after the offending stb.
- Arbiter / output FSM (IDLE, SEND):
  - IDLE: candidates are inputs n with buffer FULL and o_rdy[class_n]=1.
  - Pick the first candidate starting at pointer ptr, ascending with wrap-around N-1 -> 0. Go to SEND the next cycle.
  - Update ptr = grant+1 (mod N).
  - No candidate: remain IDLE, ptr unchanged.
  - SEND: one word per cycle, o_stb=1 contiguous for LEN+1 cycles, o_sof=1 on the first word only.
  - o_rdy is sampled only at grant; its deassertion mid-packet does not stall output.
  - After the last word, return to IDLE; a new grant may issue in that same IDLE cycle.
  - Minimum gap between packets = 1 idle cycle.
- Latency: last input word at cycle t -> buffer FULL at t+1 -> grant at t+1 -> first o_stb at t+2, given no competition and o_rdy set.
- Simultaneous events:
  - The buffer being read cannot be written (it is FULL); its EMPTY transition occurs after the last word is read.
  - A new header may arrive the cycle after i_rdy reasserts.
  - Several inputs becoming FULL in the same cycle are served in round-robin order.
- Output words are registered; o_data holds its last value when o_stb=0 (don't-care).

Test Plan:
- Single packet: input 2 sends a 4-word class-0 packet (LEN=3), o_rdy=2'b01 -> o_stb high for 4 consecutive cycles, first word at last-input+2, o_sof on word 0 only, data identical; i_rdy[2] low from the header cycle until 1 cycle after the output's last word.
- Fairness: all 5 inputs hold FULL 1-word packets, ptr=0 -> output order 0,1,2,3,4 with 1 idle cycle between packets; refill input 0 -> it is next after 4.
- Class gating: input 0 holds a class-1 packet, input 1 a class-0 packet, o_rdy=2'b01 -> input 1 is granted, input 0 waits; setting o_rdy=2'b10 -> input 0 is sent.
- Errors: stb without sof on an EMPTY input -> ff_err=1 the next cycle, no output. A 17th word (stb while FULL) -> dropped, ff_err stays 1 until rst.
- Max length and reset: 16-word packet (LEN=15) streams fully. A second packet in progress when rst is asserted mid-SEND -> o_stb=0 immediately, all buffers empty, i_rdy=2'b11 after release.
- rdyE: o_rdyE=2'b10 with input 3 EMPTY -> i_rdyE[3]=2'b10. Input 3 receives a header -> i_rdyE[3]=2'b00 the next cycle.
